// File: rtl/wb_regfile.sv
// Writeback select plus the general-purpose register file, with two combinational read ports and a commit counter.
// Define REGFILE_BYPASS_EN to let a read port see the value being written in the same cycle.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] WB_aluResult,
  input  logic [DW-1:0] WB_dmOut,
  input  logic [1:0]    WB_RegSrc,
  input  logic [31:0]   WB_rt,
  input  logic [31:0]   WB_rd,
  input  logic [1:0]    WB_RegDst,
  input  logic          WB_RegWrite,
  input  logic [DW-1:0] WB_PC,
  input  logic [4:0]    ID_rsAddr,
  input  logic [4:0]    ID_rtAddr,
  output logic [DW-1:0] ID_rsData,
  output logic [DW-1:0] ID_rtData,
  output logic [DW-1:0] wbData,
  output logic [4:0]    wbAddr,
  output logic          wbEn,
  output logic [31:0]   writeCount
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DW-1:0] regs [NREG];
  logic [31:0]   write_count;

  // Only the low five bits of the rt/rd fields name a register.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{WB_rt[31:5], WB_rd[31:5]};

  always_comb begin
    wbData = '0;
    case (WB_RegSrc)
      2'b00: wbData = WB_aluResult;
      2'b01: wbData = WB_dmOut;
      2'b10: wbData = WB_PC + DW'(4);
      2'b11: wbData = '0;
      default: wbData = '0;
    endcase
  end

  always_comb begin
    wbAddr = 5'd0;
    case (WB_RegDst)
      2'b00: wbAddr = WB_rt[4:0];
      2'b01: wbAddr = WB_rd[4:0];
      2'b10: wbAddr = 5'd31;
      2'b11: wbAddr = 5'd0;
      default: wbAddr = 5'd0;
    endcase
  end

  // With RegWrite low the enable stays low even if the selects are unknown.
  assign wbEn = WB_RegWrite && (wbAddr != 5'd0);

  always_comb begin
    ID_rsData = '0;
    if (ID_rsAddr != 5'd0) begin
      if (BYPASS && wbEn && (ID_rsAddr == wbAddr))
        ID_rsData = wbData;
      else if (32'(ID_rsAddr) < NREG)
        ID_rsData = regs[ID_rsAddr];
    end
  end

  always_comb begin
    ID_rtData = '0;
    if (ID_rtAddr != 5'd0) begin
      if (BYPASS && wbEn && (ID_rtAddr == wbAddr))
        ID_rtData = wbData;
      else if (32'(ID_rtAddr) < NREG)
        ID_rtData = regs[ID_rtAddr];
    end
  end

  // Reset takes priority over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      write_count <= '0;
    end else if (wbEn) begin
      if (32'(wbAddr) < NREG)
        regs[wbAddr] <= wbData;
      write_count <= write_count + 32'd1;
    end
  end

  assign writeCount = write_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected output values, a negedge monitor compares them.
module tb_wb_regfile;

  localparam int K_RS   = 0;
  localparam int K_RT   = 1;
  localparam int K_DATA = 2;
  localparam int K_ADDR = 3;
  localparam int K_EN   = 4;
  localparam int K_CNT  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WB_aluResult, WB_dmOut, WB_rt, WB_rd, WB_PC;
  logic [1:0]  WB_RegSrc, WB_RegDst;
  logic        WB_RegWrite;
  logic [4:0]  ID_rsAddr, ID_rtAddr;
  logic [31:0] ID_rsData, ID_rtData, wbData, writeCount;
  logic [4:0]  wbAddr;
  logic        wbEn;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_reg [32];
  logic [31:0] model_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .WB_aluResult(WB_aluResult), .WB_dmOut(WB_dmOut),
    .WB_RegSrc(WB_RegSrc), .WB_rt(WB_rt), .WB_rd(WB_rd),
    .WB_RegDst(WB_RegDst), .WB_RegWrite(WB_RegWrite), .WB_PC(WB_PC),
    .ID_rsAddr(ID_rsAddr), .ID_rtAddr(ID_rtAddr),
    .ID_rsData(ID_rsData), .ID_rtData(ID_rtData),
    .wbData(wbData), .wbAddr(wbAddr), .wbEn(wbEn), .writeCount(writeCount)
  );

  // Monitor: outputs are settled at the falling edge; drain everything queued for this cycle.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.kind)
          K_RS:    act = ID_rsData;
          K_RT:    act = ID_rtData;
          K_DATA:  act = wbData;
          K_ADDR:  act = {27'd0, wbAddr};
          K_EN:    act = {31'd0, wbEn};
          default: act = writeCount;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s actual=%h expected=%h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] src, input logic [1:0] dst, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [31:0] pc, input logic [31:0] rt,
                       input logic [31:0] rd, input logic we);
    WB_RegSrc = src; WB_RegDst = dst; WB_aluResult = alu; WB_dmOut = dm;
    WB_PC = pc; WB_rt = rt; WB_rd = rd; WB_RegWrite = we;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_cnt;
    logic [4:0]  a, prev;
    logic [31:0] d;
    logic        we;
    int          wait_cyc;

    rst = 1'b1; idle(); ID_rsAddr = 5'd0; ID_rtAddr = 5'd0;
    step(); step();

    // Load garbage, then reset with a write to reg5 pending on both reset edges.
    rst = 1'b0;
    drive(2'b00, 2'b01, 32'hAAAA_5555, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1);
    step();
    drive(2'b00, 2'b01, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 32'd8, 1'b1);
    step();
    idle(); ID_rsAddr = 5'd5; ID_rtAddr = 5'd8;
    push_exp(K_RS, 32'hAAAA_5555, "pre_reset_reg5");
    push_exp(K_RT, 32'h1234_5678, "pre_reset_reg8");
    push_exp(K_CNT, 32'd2, "pre_reset_cnt");
    step();
    rst = 1'b1;
    drive(2'b00, 2'b01, 32'h0000_0077, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1);
    step(); step();
    rst = 1'b0; idle();
    push_exp(K_RS, 32'd0, "reset_reg5");
    push_exp(K_RT, 32'd0, "reset_reg8");
    push_exp(K_CNT, 32'd0, "reset_cnt");
    exp_cnt = 32'd0;
    step();

    // ALU result to rd.
    drive(2'b00, 2'b01, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'h0000_0008, 1'b1);
    push_exp(K_DATA, 32'hDEAD_BEEF, "alu_wbdata");
    push_exp(K_ADDR, 32'd8, "rd_wbaddr");
    push_exp(K_EN, 32'd1, "alu_wben");
    step(); exp_cnt++;
    idle(); ID_rsAddr = 5'd8;
    push_exp(K_RS, 32'hDEAD_BEEF, "alu_readback");
    push_exp(K_CNT, exp_cnt, "alu_cnt");
    step();

    // jal link value, including PC wrap.
    drive(2'b10, 2'b10, 32'd0, 32'd0, 32'h0040_0010, 32'd0, 32'd0, 1'b1);
    push_exp(K_DATA, 32'h0040_0014, "jal_wbdata");
    push_exp(K_ADDR, 32'd31, "jal_wbaddr");
    step(); exp_cnt++;
    idle(); ID_rsAddr = 5'd31;
    push_exp(K_RS, 32'h0040_0014, "jal_reg31");
    step();
    drive(2'b10, 2'b10, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
    push_exp(K_DATA, 32'd0, "jal_wrap_wbdata");
    step(); exp_cnt++;
    idle();
    push_exp(K_RS, 32'd0, "jal_wrap_reg31");
    push_exp(K_CNT, exp_cnt, "jal_cnt");
    step();

    // Writes aimed at $0 are dropped; upper index bits are ignored.
    drive(2'b01, 2'b00, 32'd0, 32'h0000_1234, 32'd0, 32'h0000_0000, 32'd0, 1'b1);
    ID_rsAddr = 5'd0;
    push_exp(K_ADDR, 32'd0, "zero_wbaddr");
    push_exp(K_EN, 32'd0, "zero_wben");
    push_exp(K_DATA, 32'h0000_1234, "dm_wbdata");
    push_exp(K_RS, 32'd0, "zero_read_during");
    step();
    idle();
    push_exp(K_RS, 32'd0, "zero_read_after");
    push_exp(K_CNT, exp_cnt, "zero_cnt");
    step();
    drive(2'b01, 2'b00, 32'd0, 32'h0000_CAFE, 32'd0, 32'hFFFF_FFE3, 32'd0, 1'b1);
    push_exp(K_ADDR, 32'd3, "rt_low_bits_wbaddr");
    push_exp(K_EN, 32'd1, "rt_low_bits_wben");
    step(); exp_cnt++;
    idle(); ID_rsAddr = 5'd3;
    push_exp(K_RS, 32'h0000_CAFE, "rt_low_bits_reg3");
    push_exp(K_CNT, exp_cnt, "rt_low_bits_cnt");
    step();

    // Unknown selects with RegWrite low leave state alone.
    drive(2'bxx, 2'bxx, 32'h5555_5555, 32'h6666_6666, 32'd0, 32'd3, 32'd3, 1'b0);
    push_exp(K_EN, 32'd0, "x_sel_wben");
    step();
    idle();
    push_exp(K_RS, 32'h0000_CAFE, "x_sel_reg3");
    push_exp(K_CNT, exp_cnt, "x_sel_cnt");
    step();

    // Source 11 writes zero.
    drive(2'b11, 2'b01, 32'h0000_0055, 32'h0000_0066, 32'd0, 32'd0, 32'd3, 1'b1);
    push_exp(K_DATA, 32'd0, "src11_wbdata");
    step(); exp_cnt++;
    idle();
    push_exp(K_RS, 32'd0, "src11_reg3");
    step();

    // Same-cycle read of the register being written.
    drive(2'b00, 2'b01, 32'h0000_0011, 32'd0, 32'd0, 32'd0, 32'd4, 1'b1);
    step(); exp_cnt++;
    drive(2'b00, 2'b01, 32'h0000_0022, 32'd0, 32'd0, 32'd0, 32'd4, 1'b1);
    ID_rsAddr = 5'd4; ID_rtAddr = 5'd4;
`ifdef REGFILE_BYPASS_EN
    push_exp(K_RS, 32'h0000_0022, "raw_rs_same_cycle");
    push_exp(K_RT, 32'h0000_0022, "raw_rt_same_cycle");
`else
    push_exp(K_RS, 32'h0000_0011, "raw_rs_same_cycle");
    push_exp(K_RT, 32'h0000_0011, "raw_rt_same_cycle");
`endif
    step(); exp_cnt++;
    idle();
    push_exp(K_RS, 32'h0000_0022, "raw_rs_after");
    push_exp(K_CNT, exp_cnt, "raw_cnt");
    step();

    // Long run against a reference model, starting from a clean reset.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 32; i++) model_reg[i] = 32'd0;
    model_cnt = 32'd0;
    ID_rtAddr = 5'd0;
    for (int i = 0; i < 100; i++) begin
      a    = 5'((i % 31) + 1);
      prev = 5'(((i + 30) % 31) + 1);
      we   = (i % 4) != 3;
      d    = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      drive(2'b00, 2'b01, d, 32'd0, 32'd0, 32'd0, (32'(i) << 5) | 32'(a), we);
      ID_rsAddr = prev;
      push_exp(K_EN, {31'd0, we}, "run_wben");
      push_exp(K_RS, model_reg[prev], "run_prev_read");
      step();
      if (we) begin
        model_reg[a] = d;
        model_cnt++;
      end
    end
    idle();
    push_exp(K_CNT, model_cnt, "run_cnt");
    for (int r = 1; r < 16; r++) begin
      ID_rsAddr = 5'(r);
      ID_rtAddr = 5'(r + 16);
      push_exp(K_RS, model_reg[r], "run_final_rs");
      push_exp(K_RT, model_reg[r + 16], "run_final_rt");
      step();
    end

    // Counter wrap from a preset value.
    force dut.write_count = 32'hFFFF_FFFE;
    #1;
    release dut.write_count;
    drive(2'b00, 2'b01, 32'h0000_0001, 32'd0, 32'd0, 32'd0, 32'd9, 1'b1);
    push_exp(K_CNT, 32'hFFFF_FFFE, "wrap_preset");
    step();
    push_exp(K_CNT, 32'hFFFF_FFFF, "wrap_max");
    step();
    idle();
    push_exp(K_CNT, 32'd0, "wrap_zero");
    step();

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      step();
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
